// File: rtl/panda_lsu_bus_adapter.sv
// Multi-cycle bridge from the core's combinational data-memory port to a
// req/gnt/rvalid bus: stalls the core during an access, registers the read word.
module panda_lsu_bus_adapter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        lsu_req_i,
  input  logic [3:0]  lsu_we_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_wdata_i,
  output logic [31:0] lsu_rdata_o,
  output logic        lsu_stall_o,
  output logic        lsu_err_o,
  output logic        data_req_o,
  input  logic        data_gnt_i,
  output logic [31:0] data_addr_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i,
  input  logic        data_err_i
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

  state_e      r_state, w_state_nxt;
  logic [15:0] r_cnt;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [31:0] r_addr;
  logic        r_we;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic        w_timeout;
  logic        w_capture;
  logic        w_abort;
  logic        w_unused;

  // Byte offset is conveyed through the byte enables, not the bus address.
  assign w_unused  = ^lsu_addr_i[1:0];
  assign w_timeout = (r_cnt == 16'(TIMEOUT_CYCLES - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      IDLE: if (lsu_req_i) w_state_nxt = REQ;
      REQ: begin
        if (w_timeout) begin
          w_state_nxt = DONE;
          w_abort     = 1'b1;
        end else if (data_gnt_i) begin
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (w_timeout) begin
          w_state_nxt = DONE;
          w_abort     = 1'b1;
        end else if (data_rvalid_i) begin
          w_state_nxt = DONE;
          w_capture   = 1'b1;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_be    <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_state_nxt;

      if (r_state == IDLE) begin
        r_cnt <= '0;
      end else if (r_state == REQ || r_state == WAIT) begin
        r_cnt <= r_cnt + 16'd1;
      end

      if (r_state == IDLE && lsu_req_i) begin
        r_addr  <= {lsu_addr_i[31:2], 2'b00};
        r_we    <= |lsu_we_i;
        r_be    <= (|lsu_we_i) ? lsu_we_i : 4'b1111;
        r_wdata <= lsu_wdata_i;
      end

      if (w_capture) begin
        r_rdata <= r_we ? '0 : data_rdata_i;
        r_err   <= data_err_i;
      end else if (w_abort) begin
        r_rdata <= '0;
        r_err   <= 1'b1;
      end else if (r_state == DONE) begin
        r_err   <= 1'b0;
      end
    end
  end

  // Request is decoded from the state register, so it stays glitch-free and
  // drops with the asynchronous reset.
  assign data_req_o   = (r_state == REQ);
  assign data_addr_o  = r_addr;
  assign data_we_o    = r_we;
  assign data_be_o    = r_be;
  assign data_wdata_o = r_wdata;

  assign lsu_rdata_o  = r_rdata;
  assign lsu_err_o    = (r_state == DONE) && r_err;

  always_comb begin
    case (r_state)
      IDLE:    lsu_stall_o = lsu_req_i;
      REQ:     lsu_stall_o = 1'b1;
      WAIT:    lsu_stall_o = 1'b1;
      default: lsu_stall_o = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_panda_lsu_bus_adapter.sv
// Bench for panda_lsu_bus_adapter: scripted bus responder, expected responses
// queued at issue and compared when the access completes.
module tb_panda_lsu_bus_adapter;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic        rst_ni;
  logic        lsu_req_i, data_gnt_i, data_rvalid_i, data_err_i;
  logic [3:0]  lsu_we_i;
  logic [31:0] lsu_addr_i, lsu_wdata_i, data_rdata_i;
  logic [31:0] lsu_rdata_o, data_addr_o, data_wdata_o;
  logic        lsu_stall_o, lsu_err_o, data_req_o, data_we_o;
  logic [3:0]  data_be_o;

  logic        t_req, t_gnt, t_rvalid, t_err;
  logic [3:0]  t_we;
  logic [31:0] t_addr, t_wdata, t_rdata;
  logic [31:0] t_rdata_o, t_daddr, t_dwdata;
  logic        t_stall, t_err_o, t_dreq, t_dwe;
  logic [3:0]  t_dbe;

  panda_lsu_bus_adapter dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_addr_i(lsu_addr_i),
    .lsu_wdata_i(lsu_wdata_i), .lsu_rdata_o(lsu_rdata_o), .lsu_stall_o(lsu_stall_o),
    .lsu_err_o(lsu_err_o), .data_req_o(data_req_o), .data_gnt_i(data_gnt_i),
    .data_addr_o(data_addr_o), .data_we_o(data_we_o), .data_be_o(data_be_o),
    .data_wdata_o(data_wdata_o), .data_rvalid_i(data_rvalid_i),
    .data_rdata_i(data_rdata_i), .data_err_i(data_err_i)
  );

  panda_lsu_bus_adapter #(.TIMEOUT_CYCLES(8)) dut_to (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .lsu_req_i(t_req), .lsu_we_i(t_we), .lsu_addr_i(t_addr),
    .lsu_wdata_i(t_wdata), .lsu_rdata_o(t_rdata_o), .lsu_stall_o(t_stall),
    .lsu_err_o(t_err_o), .data_req_o(t_dreq), .data_gnt_i(t_gnt),
    .data_addr_o(t_daddr), .data_we_o(t_dwe), .data_be_o(t_dbe),
    .data_wdata_o(t_dwdata), .data_rvalid_i(t_rvalid),
    .data_rdata_i(t_rdata), .data_err_i(t_err)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // One full access on the main instance. Starts one cycle after a posedge
  // with the adapter in IDLE, returns in the cycle after DONE with lsu_req_i
  // still high so a following call runs back-to-back.
  task automatic run_access(input logic [3:0] we, input logic [31:0] addr,
                            input logic [31:0] wdata, input int gnt_dly,
                            input int rv_dly, input logic [31:0] rsp,
                            input logic rsp_err, input int exp_stall);
    logic [31:0] ea;
    logic [3:0]  ebe;
    logic        ewe;
    int          rc, wc, stalls;
    bit          granted, done;
    exp_t        e, got;
    ea  = {addr[31:2], 2'b00};
    ewe = (we != 4'b0000);
    ebe = ewe ? we : 4'b1111;
    rc = 0; wc = 0; stalls = 0; granted = 0; done = 0;
    lsu_req_i = 1'b1; lsu_we_i = we; lsu_addr_i = addr; lsu_wdata_i = wdata;
    e.rdata = ewe ? 32'h0 : rsp;
    e.err   = rsp_err;
    sb.push_back(e);
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_err_i = 1'b0;
      if (data_req_o) begin
        checks++;
        if ({data_addr_o, data_we_o, data_be_o, data_wdata_o} !== {ea, ewe, ebe, wdata}) begin
          errors++;
          $display("FAIL bus_fields addr=%h we=%b be=%b wdata=%h required addr=%h we=%b be=%b wdata=%h",
                   data_addr_o, data_we_o, data_be_o, data_wdata_o, ea, ewe, ebe, wdata);
        end
        if (rc == gnt_dly) begin
          data_gnt_i = 1'b1;
          granted = 1;
        end
        rc++;
      end else if (granted) begin
        wc++;
        if (wc == rv_dly) begin
          data_rvalid_i = 1'b1; data_rdata_i = rsp; data_err_i = rsp_err;
        end
      end
      #1;
      if (cyc == 0) begin
        checks++;
        if (lsu_err_o !== 1'b0 || lsu_stall_o !== 1'b1) begin
          errors++;
          $display("FAIL idle_start err=%b stall=%b required err=0 stall=1", lsu_err_o, lsu_stall_o);
        end
      end
      if (lsu_stall_o) begin
        stalls++;
      end else begin
        done = 1;
        got.rdata = lsu_rdata_o;
        got.err   = lsu_err_o;
        e = sb.pop_front();
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL done_result rdata=%h err=%b required rdata=%h err=%b",
                   got.rdata, got.err, e.rdata, e.err);
        end
      end
      @(posedge clk_i); #1;
    end
    data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_err_i = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      void'(sb.pop_front());
      $display("FAIL access_budget no completion within 200 cycles required completion");
    end else if (stalls != exp_stall || rc != gnt_dly + 1) begin
      errors++;
      $display("FAIL latency stall_cycles=%0d req_cycles=%0d required stall_cycles=%0d req_cycles=%0d",
               stalls, rc, exp_stall, gnt_dly + 1);
    end
  endtask

  task automatic idle_cycle();
    lsu_req_i = 1'b0; lsu_we_i = 4'b0000;
    #1;
    checks++;
    if (lsu_stall_o !== 1'b0 || lsu_err_o !== 1'b0 || data_req_o !== 1'b0) begin
      errors++;
      $display("FAIL idle stall=%b err=%b req=%b required 0 0 0", lsu_stall_o, lsu_err_o, data_req_o);
    end
    @(posedge clk_i); #1;
  endtask

  task automatic test_reset();
    checks++;
    if ({lsu_rdata_o, lsu_err_o, lsu_stall_o, data_req_o, data_we_o, data_be_o,
         data_addr_o, data_wdata_o} !== '0) begin
      errors++;
      $display("FAIL reset_state rdata=%h err=%b stall=%b req=%b we=%b be=%b addr=%h wdata=%h required all zero",
               lsu_rdata_o, lsu_err_o, lsu_stall_o, data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o);
    end
    lsu_req_i = 1'b1;
    #1;
    checks++;
    if (lsu_stall_o !== 1'b1) begin
      errors++;
      $display("FAIL idle_comb_stall stall=%b required 1", lsu_stall_o);
    end
    lsu_req_i = 1'b0;
    @(posedge clk_i); #1;
  endtask

  task automatic test_load();
    run_access(4'b0000, 32'h0000_000E, 32'h0, 0, 1, 32'hABCD_EF78, 1'b0, 3);
    idle_cycle();
    checks++;
    if (lsu_rdata_o !== 32'hABCD_EF78) begin
      errors++;
      $display("FAIL rdata_hold rdata=%h required abcdef78", lsu_rdata_o);
    end
  endtask

  task automatic test_store();
    run_access(4'b1100, 32'h0000_0016, 32'h000A_0000, 0, 1, 32'hDEAD_BEEF, 1'b0, 3);
    idle_cycle();
  endtask

  task automatic test_delayed();
    run_access(4'b0000, 32'h1234_5679, 32'h0, 5, 3, 32'h1111_2222, 1'b0, 10);
    idle_cycle();
  endtask

  task automatic test_bus_error();
    run_access(4'b0000, 32'h0000_0040, 32'h0, 1, 2, 32'h3333_4444, 1'b1, 5);
    idle_cycle();
  endtask

  task automatic test_back_to_back();
    run_access(4'b0001, 32'h0000_0101, 32'h0000_00AB, 0, 1, 32'h9999_9999, 1'b0, 3);
    run_access(4'b1111, 32'h0000_0300, 32'hFEED_FACE, 0, 2, 32'h0, 1'b0, 4);
    run_access(4'b0000, 32'h0000_0200, 32'h0, 0, 1, 32'h5A5A_A5A5, 1'b0, 3);
    idle_cycle();
  endtask

  task automatic test_timeout();
    int   reqs, stalls;
    bit   done;
    exp_t e, got;
    t_req = 1'b1; t_addr = 32'h8;
    @(posedge clk_i); #1; t_gnt = 1'b1;
    @(posedge clk_i); #1; t_gnt = 1'b0; t_rvalid = 1'b1; t_rdata = 32'hCAFE_F00D;
    @(posedge clk_i); #1; t_rvalid = 1'b0;
    checks++;
    if (t_rdata_o !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL to_preload rdata=%h required cafef00d", t_rdata_o);
    end
    @(posedge clk_i); #1;
    e.rdata = 32'h0; e.err = 1'b1;
    sb.push_back(e);
    reqs = 0; stalls = 0; done = 0;
    for (int cyc = 0; cyc < 50 && !done; cyc++) begin
      #1;
      if (t_dreq) reqs++;
      if (t_stall) begin
        stalls++;
      end else begin
        done = 1;
        got.rdata = t_rdata_o; got.err = t_err_o;
        e = sb.pop_front();
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL timeout_result rdata=%h err=%b required rdata=%h err=%b",
                   got.rdata, got.err, e.rdata, e.err);
        end
      end
      @(posedge clk_i); #1;
    end
    checks++;
    if (!done) begin
      errors++;
      void'(sb.pop_front());
      $display("FAIL timeout_budget no completion within 50 cycles required completion");
    end else if (reqs != 8 || stalls != 9) begin
      errors++;
      $display("FAIL timeout_latency req_cycles=%0d stall_cycles=%0d required 8 9", reqs, stalls);
    end
    t_req = 1'b0; t_rvalid = 1'b1; t_rdata = 32'h5555_5555; t_err = 1'b1;
    @(posedge clk_i); #1;
    t_rvalid = 1'b0; t_err = 1'b0;
    @(posedge clk_i); #1;
    checks++;
    if (t_rdata_o !== 32'h0 || t_err_o !== 1'b0 || t_stall !== 1'b0 || t_dreq !== 1'b0) begin
      errors++;
      $display("FAIL late_rvalid rdata=%h err=%b stall=%b req=%b required 0 0 0 0",
               t_rdata_o, t_err_o, t_stall, t_dreq);
    end
  endtask

  task automatic test_reset_mid();
    lsu_req_i = 1'b1; lsu_we_i = 4'b0000; lsu_addr_i = 32'h0000_0084;
    @(posedge clk_i); #1; data_gnt_i = 1'b1;
    @(posedge clk_i); #1; data_gnt_i = 1'b0;
    checks++;
    if (lsu_stall_o !== 1'b1 || data_req_o !== 1'b0) begin
      errors++;
      $display("FAIL in_wait stall=%b req=%b required 1 0", lsu_stall_o, data_req_o);
    end
    lsu_req_i = 1'b0;
    #1 rst_ni = 1'b0;
    #1;
    checks++;
    if (data_req_o !== 1'b0 || lsu_stall_o !== 1'b0 || lsu_err_o !== 1'b0 ||
        lsu_rdata_o !== 32'h0 || data_addr_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid req=%b stall=%b err=%b rdata=%h addr=%h required all zero",
               data_req_o, lsu_stall_o, lsu_err_o, lsu_rdata_o, data_addr_o);
    end
    @(posedge clk_i); #1 rst_ni = 1'b1;
    @(posedge clk_i); #1;
    run_access(4'b0000, 32'h0000_0088, 32'h0, 0, 1, 32'h7777_0001, 1'b0, 3);
    idle_cycle();
  endtask

  initial begin
    rst_ni = 1'b0;
    lsu_req_i = 1'b0; lsu_we_i = '0; lsu_addr_i = '0; lsu_wdata_i = '0;
    data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = '0; data_err_i = 1'b0;
    t_req = 1'b0; t_we = '0; t_addr = '0; t_wdata = '0;
    t_gnt = 1'b0; t_rvalid = 1'b0; t_rdata = '0; t_err = 1'b0;
    @(posedge clk_i); @(posedge clk_i); #1 rst_ni = 1'b1;
    @(posedge clk_i); #1;
    test_reset();
    test_load();
    test_store();
    test_delayed();
    test_bus_error();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
